// File: rtl/apb_pkg.sv
// Shared APB definitions for the completer register file and the master bridge:
// bus widths, transfer state encoding and the read data returned on an error.
package apb_pkg;

    localparam int APB_DW = 32;
    localparam int APB_AW = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } apb_state_t;

    localparam logic [APB_DW-1:0] APB_ERR_RDATA = '0;

endpackage

// File: rtl/apb_regfile.sv
// DEPTH x 32 register array: one synchronous write port, one combinational
// read port, every entry returns to RESET_VAL on reset.
module apb_regfile
    import apb_pkg::*;
#(
    parameter int                DEPTH     = 16,
    parameter logic [APB_DW-1:0] RESET_VAL = '0,
    localparam int               IW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IW-1:0]     wr_idx,
    input  logic [APB_DW-1:0] wr_data,
    input  logic [IW-1:0]     rd_idx,
    output logic [APB_DW-1:0] rd_data
);

    logic [APB_DW-1:0] mem_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_reg
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    mem_reg[gi] <= RESET_VAL;
                end else if (wr_en && (wr_idx == IW'(gi))) begin
                    mem_reg[gi] <= wr_data;
                end
            end
        end
    endgenerate

    assign rd_data = mem_reg[rd_idx];

endmodule

// File: rtl/apb_slave_regfile.sv
// APB completer in front of a small register file, with a fixed number of
// PREADY-low wait states per access and PSLVERR on out-of-range addresses.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int                DEPTH       = 16,
    parameter int                ADDR_LSB    = 1,
    parameter int                WAIT_CYCLES = 1,
    parameter logic [APB_DW-1:0] RESET_VAL   = '0
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [APB_AW-1:0] PADDR,
    input  logic [APB_DW-1:0] PWDATA,
    output logic [APB_DW-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR
);

    localparam int IW     = $clog2(DEPTH);
    localparam int HI_LSB = ADDR_LSB + IW;
    localparam int CW     = 4;

    apb_state_t        state_reg, state_next;
    logic [CW-1:0]     cnt_reg, cnt_next;
    logic              write_reg, write_next;
    logic              err_reg, err_next;
    logic [IW-1:0]     idx_reg, idx_next;
    logic [APB_DW-1:0] wdata_reg, wdata_next;
    logic [APB_DW-1:0] prdata_reg, prdata_next;
    logic              pready_reg, pready_next;
    logic              pslverr_reg, pslverr_next;

    logic              setup;
    logic              addr_err;
    logic              addr_unused;
    logic [IW-1:0]     addr_idx;
    logic [IW-1:0]     rd_idx;
    logic [APB_DW-1:0] rd_data;
    logic              cur_write;
    logic              cur_err;
    logic              wr_en;

    assign setup       = PSEL && !PENABLE;
    assign addr_idx    = PADDR[ADDR_LSB +: IW];
    assign addr_err    = (PADDR >> HI_LSB) != '0;
    assign addr_unused = ^PADDR;

    // With zero wait states the response is built on the setup edge itself,
    // so the live bus fields are used until they have been latched.
    assign rd_idx    = (state_reg == ST_IDLE) ? addr_idx : idx_reg;
    assign cur_write = (state_reg == ST_IDLE) ? PWRITE   : write_reg;
    assign cur_err   = (state_reg == ST_IDLE) ? addr_err : err_reg;

    assign wr_en = (state_reg == ST_RESP) && PSEL && PENABLE && write_reg && !err_reg;

    apb_regfile #(
        .DEPTH    (DEPTH),
        .RESET_VAL(RESET_VAL)
    ) u_regfile (
        .clk    (PCLK),
        .rst    (PRESET),
        .wr_en  (wr_en),
        .wr_idx (idx_reg),
        .wr_data(wdata_reg),
        .rd_idx (rd_idx),
        .rd_data(rd_data)
    );

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_reg   <= ST_IDLE;
            cnt_reg     <= '0;
            write_reg   <= 1'b0;
            err_reg     <= 1'b0;
            idx_reg     <= '0;
            wdata_reg   <= '0;
            prdata_reg  <= '0;
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            write_reg   <= write_next;
            err_reg     <= err_next;
            idx_reg     <= idx_next;
            wdata_reg   <= wdata_next;
            prdata_reg  <= prdata_next;
            pready_reg  <= pready_next;
            pslverr_reg <= pslverr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (setup) state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
            ST_WAIT: begin
                if (!PSEL)              state_next = ST_IDLE;
                else if (cnt_reg == '0) state_next = ST_RESP;
            end
            ST_RESP: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_next     = cnt_reg;
        write_next   = write_reg;
        err_next     = err_reg;
        idx_next     = idx_reg;
        wdata_next   = wdata_reg;
        prdata_next  = '0;
        pready_next  = 1'b0;
        pslverr_next = 1'b0;

        if ((state_reg == ST_IDLE) && setup) begin
            write_next = PWRITE;
            err_next   = addr_err;
            idx_next   = addr_idx;
            wdata_next = PWDATA;
            cnt_next   = (WAIT_CYCLES == 0) ? '0 : CW'(WAIT_CYCLES - 1);
        end

        if ((state_reg == ST_WAIT) && (state_next == ST_WAIT)) begin
            cnt_next = cnt_reg - 1'b1;
        end

        if (state_next == ST_RESP) begin
            pready_next  = 1'b1;
            pslverr_next = cur_err;
            if (!cur_write) prdata_next = cur_err ? APB_ERR_RDATA : rd_data;
        end
    end

    assign PRDATA  = prdata_reg;
    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Three completers (1, 0 and 3 wait states) on one shared bus, checked
// against an array model of register contents and expected access lengths.
module tb_apb_slave_regfile;

    localparam int NDUT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [NDUT-1:0] psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata  [NDUT];
    logic        pready  [NDUT];
    logic        pslverr [NDUT];

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] model [NDUT][16];

    always #5 clk = ~clk;

    genvar gi;
    generate
        for (gi = 0; gi < NDUT; gi++) begin : g_dut
            apb_slave_regfile #(
                .DEPTH      (16),
                .ADDR_LSB   (1),
                .WAIT_CYCLES((gi == 0) ? 1 : ((gi == 1) ? 0 : 3)),
                .RESET_VAL  (32'h0)
            ) u_dut (
                .PCLK   (clk),
                .PRESET (rst),
                .PSEL   (psel[gi]),
                .PENABLE(penable),
                .PWRITE (pwrite),
                .PADDR  (paddr),
                .PWDATA (pwdata),
                .PRDATA (prdata[gi]),
                .PREADY (pready[gi]),
                .PSLVERR(pslverr[gi])
            );
        end
    endgenerate

    function automatic int waits_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 0 : 3);
    endfunction

    // Out of range when any address bit above the 4-bit index (bits 4:1) is set.
    function automatic bit addr_is_err(input logic [31:0] a);
        return (a >> 5) != 32'h0;
    endfunction

    function automatic int idx_of(input logic [31:0] a);
        return int'(a[4:1]);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < NDUT; d++)
            for (int i = 0; i < 16; i++) model[d][i] = 32'h0;
    endtask

    task automatic check_outputs_zero(input int d, input string tag);
        check({tag, "_prdata"}, prdata[d], 32'h0);
        check({tag, "_pready"}, {31'b0, pready[d]}, 32'h0);
        check({tag, "_pslverr"}, {31'b0, pslverr[d]}, 32'h0);
    endtask

    // Full setup + access transfer; called and returns #1 after a rising edge.
    task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input string tag);
        logic [31:0] exp_rd;
        logic [31:0] got_rd;
        bit          exp_err;
        logic        got_err;
        int          acc;
        exp_err = addr_is_err(addr);
        exp_rd  = (wr || exp_err) ? 32'h0 : model[d][idx_of(addr)];
        psel[d] = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
        @(posedge clk); #1;
        penable = 1'b1;
        pwdata  = $urandom;
        acc     = 1;
        while (!pready[d] && acc < 40) begin
            @(posedge clk); #1;
            acc++;
        end
        got_rd  = prdata[d];
        got_err = pslverr[d];
        check({tag, "_acc"}, 32'(acc), 32'(waits_of(d) + 1));
        check({tag, "_err"}, {31'b0, got_err}, {31'b0, exp_err});
        if (!wr) check({tag, "_rdata"}, got_rd, exp_rd);
        @(posedge clk); #1;
        check({tag, "_done"}, {31'b0, pready[d]}, 32'h0);
        psel[d] = 1'b0; penable = 1'b0;
        if (wr && !exp_err) model[d][idx_of(addr)] = wdata;
        $display("xfer %-10s dut=%0d %s addr=%h wdata=%h rdata=%h err=%0d access=%0d",
                 tag, d, wr ? "WR" : "RD", addr, wdata, got_rd, got_err, acc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        rst = 1'b0; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        model_reset();

        // Reset asserted mid-cycle, then read of 0x4 on the 1-wait instance.
        @(posedge clk); #3;
        rst = 1'b1; #1;
        for (int d = 0; d < NDUT; d++) check_outputs_zero(d, "reset");
        @(posedge clk); #1;
        rst = 1'b0;
        xfer(0, 1'b0, 32'h4, 32'h0, "rst_read");

        // Write then read back through idx 3.
        xfer(0, 1'b1, 32'h6, 32'hDEADBEEF, "wr_beef");
        xfer(0, 1'b0, 32'h6, 32'h0, "rd_beef");

        // Zero-wait instance, back-to-back transfers.
        xfer(1, 1'b1, 32'h0, 32'h11, "zw_wr0");
        xfer(1, 1'b1, 32'h2, 32'h22, "zw_wr1");
        xfer(1, 1'b0, 32'h0, 32'h0, "zw_rd0");
        xfer(1, 1'b0, 32'h2, 32'h0, "zw_rd1");

        // Out of range write must leave idx 0 (which aliases 0x40's low bits) alone.
        xfer(0, 1'b1, 32'h0, 32'h12345678, "pre_idx0");
        xfer(0, 1'b1, 32'h40, 32'hFFFF, "oor_wr");
        xfer(0, 1'b0, 32'h40, 32'h0, "oor_rd");
        xfer(0, 1'b0, 32'h0, 32'h0, "oor_idx0");

        // Abort: PSEL drops in the 2nd access cycle of a 3-wait write.
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'hA5;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = pready[2];
        @(posedge clk); #1;
        seen |= pready[2];
        psel[2] = 1'b0; penable = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            seen |= pready[2];
        end
        check("abort_noready", {31'b0, seen}, 32'h0);
        xfer(2, 1'b0, 32'h4, 32'h0, "abort_rd");
        xfer(2, 1'b1, 32'h4, 32'h77, "pre_rst_wr");

        // Reset while a read response is being presented clears outputs at once.
        psel[0] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h6; pwdata = 32'h0;
        @(posedge clk); #1;
        penable = 1'b1;
        @(posedge clk); #1;
        check("resp_pready", {31'b0, pready[0]}, 32'h1);
        check("resp_prdata", prdata[0], model[0][3]);
        #2 rst = 1'b1; #1;
        check_outputs_zero(0, "rst_resp");
        @(posedge clk); #1;
        rst = 1'b0; psel = '0; penable = 1'b0;
        model_reset();

        // Reset during the WAIT state of a write to idx 2.
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4; pwdata = 32'h5A;
        @(posedge clk); #1;
        penable = 1'b1;
        seen = pready[2];
        @(posedge clk); #1;
        seen |= pready[2];
        #2 rst = 1'b1; #1;
        seen |= pready[2];
        check_outputs_zero(2, "rst_wait");
        @(posedge clk); #1;
        rst = 1'b0; psel = '0; penable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            seen |= pready[2];
        end
        check("rst_wait_noready", {31'b0, seen}, 32'h0);
        xfer(2, 1'b0, 32'h4, 32'h0, "rst_idx2");

        // Illegal sequence: access phase with no setup phase, on two instances.
        xfer(0, 1'b1, 32'h2, 32'h0BAD0BAD, "pre_ill0");
        xfer(1, 1'b1, 32'h2, 32'h0BAD0BAD, "pre_ill1");
        psel[0] = 1'b1; psel[1] = 1'b1; penable = 1'b1; pwrite = 1'b1;
        paddr = 32'h2; pwdata = 32'hCAFEF00D;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("illegal_pready0", {31'b0, pready[0]}, 32'h0);
            check("illegal_pready1", {31'b0, pready[1]}, 32'h0);
        end
        psel = '0; penable = 1'b0;
        @(posedge clk); #1;
        xfer(0, 1'b0, 32'h2, 32'h0, "ill_rd0");
        xfer(1, 1'b0, 32'h2, 32'h0, "ill_rd1");

        // Randomized traffic against the model.
        for (int n = 0; n < 80; n++) begin
            int          d;
            bit          wr;
            logic [31:0] addr;
            d  = int'($urandom_range(0, NDUT - 1));
            wr = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) addr = $urandom | 32'h100;
            else                           addr = 32'($urandom_range(0, 31));
            xfer(d, wr, addr, $urandom, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
